cluster_unpacker: RTL and testbench

//  Inverse of the cluster finder. Takes one packed cluster list per latch: MXCLUSTERS entries of {vpf, adr, cnt}.

---
 rtl/cluster_unpacker_pkg.sv | 37 +++
 rtl/cluster_unpacker_if.sv | 29 ++
 rtl/cluster_unpacker_mask_gen.sv | 25 ++
 rtl/cluster_unpacker.sv | 112 +++++++++++
 tb/tb_cluster_unpacker.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_unpacker_pkg.sv
// Shared constants and slot type for the cluster unpacker.
// Strip-space geometry lives here so every file agrees on widths.
package cluster_unpacker_pkg;

  localparam int MXSBITS    = 64;
  localparam int MXVFATS    = 24;
  localparam int MXSTRIPS   = MXSBITS * MXVFATS;
  localparam int MXCLUSTERS = 8;
  localparam int MXADRBITS  = 11;
  localparam int MXCNTBITS  = 3;

  localparam int PASSBITS = $clog2(MXCLUSTERS);
  localparam int XBITS    = 12;

  localparam int ADRW = MXCLUSTERS * MXADRBITS;
  localparam int CNTW = MXCLUSTERS * MXCNTBITS;

  typedef struct packed {
    logic                 vpf;
    logic [MXADRBITS-1:0] adr;
    logic [MXCNTBITS-1:0] cnt;
  } slot_t;

  function automatic slot_t pick_slot(
    input logic [MXCLUSTERS-1:0] vpf,
    input logic [ADRW-1:0]       adr,
    input logic [CNTW-1:0]       cnt,
    input logic [PASSBITS-1:0]   idx
  );
    slot_t s;
    s.vpf = vpf[idx];
    s.adr = adr[int'(idx)*MXADRBITS +: MXADRBITS];
    s.cnt = cnt[int'(idx)*MXCNTBITS +: MXCNTBITS];
    return s;
  endfunction

endpackage

// File: rtl/cluster_unpacker_if.sv
// Cluster-list input bus and reconstructed hit-map output bus.
// master drives the list; slave is the unpacker.
interface cluster_unpacker_if;
  import cluster_unpacker_pkg::*;

  logic                  latch_in;
  logic [MXCLUSTERS-1:0] vpf_in;
  logic [ADRW-1:0]       adr_in;
  logic [CNTW-1:0]       cnt_in;

  logic [MXSTRIPS-1:0]   vpfs_out;
  logic                  valid_out;
  logic                  busy;
  logic                  overflow;
  logic                  adr_err;

  modport master (
    output latch_in, vpf_in, adr_in, cnt_in,
    input  vpfs_out, valid_out, busy,
    input  overflow, adr_err
  );

  modport slave (
    input  latch_in, vpf_in, adr_in, cnt_in,
    output vpfs_out, valid_out, busy,
    output overflow, adr_err
  );

endinterface

// File: rtl/cluster_unpacker_mask_gen.sv
// Combinational {adr,cnt} -> clipped strip mask; no wrap past the top.
// 12-bit bounds keep adr+cnt from aliasing back into range.
module cluster_mask_gen
  import cluster_unpacker_pkg::*;
(
  input  logic [MXADRBITS-1:0] adr,
  input  logic [MXCNTBITS-1:0] cnt,
  output logic [MXSTRIPS-1:0]  mask,
  output logic                 adr_bad
);

  logic [XBITS-1:0] lo;
  logic [XBITS-1:0] hi;

  assign lo = XBITS'(adr);
  assign hi = lo + XBITS'(cnt);

  assign adr_bad = (lo >= XBITS'(MXSTRIPS));

  for (genvar i = 0; i < MXSTRIPS; i++) begin : g_bit
    assign mask[i] = (lo <= XBITS'(i)) &&
                     (hi >= XBITS'(i));
  end

endmodule

// File: rtl/cluster_unpacker.sv
// Serial cluster-list to hit-map rebuilder, one slot per clock.
// IDLE -> RUN (MXCLUSTERS passes) -> DONE (publish map) -> IDLE/RUN.
module cluster_unpacker
  import cluster_unpacker_pkg::*;
(
  input logic               clock,
  input logic               reset,
  cluster_unpacker_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PASSBITS-1:0] LAST =
    PASSBITS'(MXCLUSTERS - 1);

  logic [1:0]            state_q, state_d;
  logic [PASSBITS-1:0]   pass_q, pass_d;
  logic [MXCLUSTERS-1:0] vpf_q, vpf_d;
  logic [ADRW-1:0]       adr_q, adr_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [MXSTRIPS-1:0]   acc_q, acc_d;
  logic [MXSTRIPS-1:0]   vpfs_q, vpfs_d;
  logic                  ovf_q, ovf_d;
  logic                  aerr_q, aerr_d;

  slot_t               cur;
  logic [MXSTRIPS-1:0] cur_mask;
  logic                cur_bad;

  assign cur = pick_slot(vpf_q, adr_q, cnt_q, pass_q);

  cluster_mask_gen u_mask (
    .adr     (cur.adr),
    .cnt     (cur.cnt),
    .mask    (cur_mask),
    .adr_bad (cur_bad)
  );

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    vpf_d   = vpf_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    vpfs_d  = vpfs_q;
    ovf_d   = 1'b0;
    aerr_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_RUN): begin
        ovf_d = bus.latch_in;
        if (cur.vpf) begin
          acc_d  = acc_q | cur_mask;
          aerr_d = cur_bad;
        end
        if (pass_q == LAST) begin
          vpfs_d  = acc_d;
          pass_d  = '0;
          state_d = S_DONE;
        end else begin
          pass_d = pass_q + 1'b1;
        end
      end
      // IDLE and DONE both accept a new list; DONE otherwise idles
      default: begin
        if (bus.latch_in) begin
          vpf_d   = bus.vpf_in;
          adr_d   = bus.adr_in;
          cnt_d   = bus.cnt_in;
          acc_d   = '0;
          pass_d  = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      vpf_q   <= '0;
      adr_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      vpfs_q  <= '0;
      ovf_q   <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      vpf_q   <= vpf_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      vpfs_q  <= vpfs_d;
      ovf_q   <= ovf_d;
      aerr_q  <= aerr_d;
    end
  end

  assign bus.vpfs_out  = vpfs_q;
  assign bus.valid_out = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.overflow  = ovf_q;
  assign bus.adr_err   = aerr_q;

endmodule

// File: tb/tb_cluster_unpacker.sv
// Randomized bench for cluster_unpacker against a cycle-indexed
// behavioural model, plus directed literal checks and a finder round trip.
module tb_cluster_unpacker;
  import cluster_unpacker_pkg::*;

  localparam int NS  = MXSTRIPS;
  localparam int NC  = MXCLUSTERS;
  localparam int LAT = NC + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cluster_unpacker_if bus();

  cluster_unpacker dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int aerr_seen = 0;
  bit chk_en = 1'b0;

  // model: expected events keyed by the cycle they must be visible
  bit            e_valid[int];
  bit            e_busy[int];
  bit            e_ovf[int];
  bit            e_aerr[int];
  bit            e_clr[int];
  logic [NS-1:0] e_map[int];
  logic [NS-1:0] exp_hold = '0;
  int            run_start = -1000;

  bit sv[NC];
  int sa[NC];
  int sc[NC];

  task automatic model_latch(input int t);
    logic [NS-1:0] m;
    if (t - run_start >= 1 && t - run_start <= NC) begin
      e_ovf[t+1] = 1'b1;
    end else begin
      run_start = t;
      for (int k = 1; k <= NC; k++) e_busy[t+k] = 1'b1;
      m = '0;
      for (int s = 0; s < NC; s++) begin
        if (sv[s]) begin
          if (sa[s] >= NS) e_aerr[t+s+2] = 1'b1;
          else
            for (int b = sa[s]; b <= sa[s] + sc[s] && b < NS; b++)
              m[b] = 1'b1;
        end
      end
      e_valid[t+LAT] = 1'b1;
      e_map[t+LAT] = m;
    end
  endtask

  task automatic model_reset(input int r);
    for (int k = r + 1; k <= r + 24; k++) begin
      if (e_valid.exists(k)) e_valid.delete(k);
      if (e_busy.exists(k))  e_busy.delete(k);
      if (e_ovf.exists(k))   e_ovf.delete(k);
      if (e_aerr.exists(k))  e_aerr.delete(k);
      if (e_map.exists(k))   e_map.delete(k);
    end
    e_clr[r+1] = 1'b1;
    run_start = -1000;
  endtask

  always @(negedge clock) begin : chk
    bit ev, eb, eo, ea;
    if (chk_en) begin
      if (e_clr.exists(cyc)) exp_hold = '0;
      ev = e_valid.exists(cyc);
      if (ev) exp_hold = e_map[cyc];
      eb = e_busy.exists(cyc);
      eo = e_ovf.exists(cyc);
      ea = e_aerr.exists(cyc);
      if (bus.adr_err === 1'b1) aerr_seen++;
      vectors++;
      if (bus.valid_out !== ev) begin
        miscompares++;
        $display("FAIL valid_out cyc=%0d got=%b exp=%b",
                 cyc, bus.valid_out, ev);
      end
      if (bus.busy !== eb) begin
        miscompares++;
        $display("FAIL busy cyc=%0d got=%b exp=%b",
                 cyc, bus.busy, eb);
      end
      if (bus.overflow !== eo) begin
        miscompares++;
        $display("FAIL overflow cyc=%0d got=%b exp=%b",
                 cyc, bus.overflow, eo);
      end
      if (bus.adr_err !== ea) begin
        miscompares++;
        $display("FAIL adr_err cyc=%0d got=%b exp=%b",
                 cyc, bus.adr_err, ea);
      end
      if (bus.vpfs_out !== exp_hold) begin
        miscompares++;
        $display("FAIL vpfs_out cyc=%0d got_ones=%0d exp_ones=%0d",
                 cyc, $countones(bus.vpfs_out), $countones(exp_hold));
      end
    end
  end

  task automatic lit(input string nm, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic scramble();
    bus.vpf_in = NC'($urandom);
    for (int s = 0; s < NC; s++) begin
      bus.adr_in[s*MXADRBITS +: MXADRBITS] = MXADRBITS'($urandom);
      bus.cnt_in[s*MXCNTBITS +: MXCNTBITS] = MXCNTBITS'($urandom);
    end
  endtask

  task automatic clear_list();
    for (int s = 0; s < NC; s++) begin
      sv[s] = 1'b0;
      sa[s] = $urandom_range(0, 2047);
      sc[s] = $urandom_range(0, 7);
    end
  endtask

  task automatic rand_list();
    for (int s = 0; s < NC; s++) begin
      sv[s] = 1'($urandom_range(0, 1));
      sa[s] = ($urandom_range(0, 7) == 0) ?
              $urandom_range(NS - 8, 2047) :
              $urandom_range(0, NS - 1);
      sc[s] = $urandom_range(0, 7);
    end
  endtask

  task automatic issue();
    for (int s = 0; s < NC; s++) begin
      bus.vpf_in[s] = sv[s];
      bus.adr_in[s*MXADRBITS +: MXADRBITS] = MXADRBITS'(sa[s]);
      bus.cnt_in[s*MXCNTBITS +: MXCNTBITS] = MXCNTBITS'(sc[s]);
    end
    bus.latch_in = 1'b1;
    model_latch(cyc);
    step();
    bus.latch_in = 1'b0;
    scramble();
  endtask

  initial begin
    int t;
    int a0;
    int nrun, st, ln, off, k, b;
    int ca[$];
    int cc[$];
    logic [NS-1:0] m;

    bus.latch_in = 1'b0;
    scramble();
    repeat (3) step();
    reset = 1'b0;
    chk_en = 1'b1;
    lit("reset_valid", int'(bus.valid_out), 0);
    lit("reset_busy", int'(bus.busy), 0);
    lit("reset_map", $countones(bus.vpfs_out), 0);
    step();

    // single cluster at 100, size 3
    clear_list();
    sv[0] = 1'b1; sa[0] = 100; sc[0] = 2;
    t = cyc; issue();
    wait_to(t + LAT - 1);
    @(negedge clock);
    lit("t1_early_valid", int'(bus.valid_out), 0);
    wait_to(t + LAT);
    @(negedge clock);
    lit("t1_valid", int'(bus.valid_out), 1);
    lit("t1_b100", int'(bus.vpfs_out[100]), 1);
    lit("t1_b102", int'(bus.vpfs_out[102]), 1);
    lit("t1_b103", int'(bus.vpfs_out[103]), 0);
    lit("t1_ones", $countones(bus.vpfs_out), 3);
    step(); step();

    // clipping at the top, no wrap
    clear_list();
    sv[2] = 1'b1; sa[2] = 1534; sc[2] = 7;
    a0 = aerr_seen;
    t = cyc; issue();
    wait_to(t + LAT);
    @(negedge clock);
    lit("t2_b1535", int'(bus.vpfs_out[1535]), 1);
    lit("t2_b0", int'(bus.vpfs_out[0]), 0);
    lit("t2_ones", $countones(bus.vpfs_out), 2);
    lit("t2_aerr", aerr_seen - a0, 0);
    step(); step();

    // out-of-range slot 3
    clear_list();
    sv[0] = 1'b1; sa[0] = 10; sc[0] = 0;
    sv[3] = 1'b1; sa[3] = 1600; sc[3] = 1;
    t = cyc; issue();
    wait_to(t + 4);
    @(negedge clock);
    lit("t3_aerr_t4", int'(bus.adr_err), 0);
    wait_to(t + 5);
    @(negedge clock);
    lit("t3_aerr_t5", int'(bus.adr_err), 1);
    wait_to(t + LAT);
    @(negedge clock);
    lit("t3_ones", $countones(bus.vpfs_out), 1);
    lit("t3_b10", int'(bus.vpfs_out[10]), 1);
    step(); step();

    // latch during RUN is dropped
    clear_list();
    sv[0] = 1'b1; sa[0] = 200; sc[0] = 1;
    t = cyc; issue();
    wait_to(t + 4);
    sa[0] = 300;
    issue();
    @(negedge clock);
    lit("t4_ovf", int'(bus.overflow), 1);
    wait_to(t + LAT);
    @(negedge clock);
    lit("t4_valid", int'(bus.valid_out), 1);
    lit("t4_b200", int'(bus.vpfs_out[200]), 1);
    lit("t4_b300", int'(bus.vpfs_out[300]), 0);
    step();
    @(negedge clock);
    lit("t4_single", int'(bus.valid_out), 0);
    step(); step();

    // back-to-back latch during DONE
    clear_list();
    sv[0] = 1'b1; sa[0] = 400; sc[0] = 0;
    t = cyc; issue();
    wait_to(t + LAT);
    lit("t5_valid1", int'(bus.valid_out), 1);
    clear_list();
    sv[4] = 1'b1; sa[4] = 500; sc[4] = 3;
    issue();
    wait_to(t + 2 * LAT);
    @(negedge clock);
    lit("t5_valid2", int'(bus.valid_out), 1);
    lit("t5_b400", int'(bus.vpfs_out[400]), 0);
    lit("t5_ones", $countones(bus.vpfs_out), 4);
    step(); step();

    // overlapping/duplicate clusters OR together
    clear_list();
    sv[1] = 1'b1; sa[1] = 700; sc[1] = 3;
    sv[5] = 1'b1; sa[5] = 700; sc[5] = 3;
    sv[6] = 1'b1; sa[6] = 702; sc[6] = 4;
    t = cyc; issue();
    wait_to(t + LAT);
    @(negedge clock);
    lit("ovl_ones", $countones(bus.vpfs_out), 7);
    lit("ovl_b706", int'(bus.vpfs_out[706]), 1);
    step(); step();

    // empty list still publishes
    clear_list();
    t = cyc; issue();
    wait_to(t + LAT);
    @(negedge clock);
    lit("empty_valid", int'(bus.valid_out), 1);
    lit("empty_ones", $countones(bus.vpfs_out), 0);
    step(); step();

    // reset mid-run
    clear_list();
    sv[0] = 1'b1; sa[0] = 600; sc[0] = 5;
    t = cyc; issue();
    wait_to(t + 4);
    reset = 1'b1;
    model_reset(cyc);
    step();
    reset = 1'b0;
    wait_to(t + LAT);
    @(negedge clock);
    lit("rst_valid", int'(bus.valid_out), 0);
    lit("rst_ones", $countones(bus.vpfs_out), 0);
    step(); step();

    // random traffic incl. overflow and DONE-cycle latches
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rand_list();
        issue();
      end else begin
        step();
      end
    end
    repeat (12) step();

    // map -> finder -> unpacker round trip
    for (int e = 0; e < 1500; e++) begin
      m = '0;
      nrun = $urandom_range(0, 5);
      for (int r = 0; r < nrun; r++) begin
        st = $urandom_range(0, NS - 1);
        ln = $urandom_range(1, 12);
        for (int x = st; x < st + ln && x < NS; x++) m[x] = 1'b1;
      end
      ca.delete(); cc.delete();
      b = 0;
      while (b < NS) begin
        if (m[b]) begin
          k = 0;
          while (b + k < NS && m[b+k] && k < NC) k++;
          ca.push_back(b); cc.push_back(k - 1);
          b = b + k;
        end else begin
          b++;
        end
      end
      if (ca.size() <= NC) begin
        clear_list();
        off = $urandom_range(0, NC - 1);
        foreach (ca[j]) begin
          sv[(j + off) % NC] = 1'b1;
          sa[(j + off) % NC] = ca[j];
          sc[(j + off) % NC] = cc[j];
        end
        t = cyc; issue();
        wait_to(t + LAT);
        lit("closure", int'(bus.vpfs_out === m), 1);
      end else begin
        step();
      end
    end
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
